// File: rtl/cover_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cover_pkg
// Description : Shared types and helpers for the toggle-coverage collectors.
//               Holds the global cover-index type, the design-wide default
//               cover-point total and a popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cover_pkg;

    // Global cover index as delivered to the harness (unsigned, 64-bit).
    typedef logic [63:0] cover_index_t;

    // Total cover points in the instrumented design; used for range checks.
    localparam int unsigned c_COVER_TOTAL_DEFAULT = 8744;

    // Widest hit vector a single collector instance may handle.
    localparam int unsigned c_MAX_WIDTH = 64;

    // Number of set bits in a (zero-extended) hit vector.
    function automatic logic [6:0] popcount(input logic [63:0] vec);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {6'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cover_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : cover_prio_enc
// Description : Lowest-set-bit priority encoder for cover-point request
//               vectors. Shared by collectors of any width.
// Ports       : req    - request vector (WIDTH bits)
//               found  - at least one bit of req is set
//               bitpos - position of the lowest set bit (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module cover_prio_enc #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0]                           req,
    output logic                                       found,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] bitpos
);

    localparam int c_POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Scanning from the top down lets the lowest set bit win by being the
    // last assignment.
    always_comb begin
        found  = 1'b0;
        bitpos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found  = 1'b1;
                bitpos = c_POS_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/toggle_cover_collector.sv
`default_nettype none
// ============================================================================
// Module      : toggle_cover_collector
// Description : Samples a per-point hit vector every cycle, keeps a sticky
//               covered bitmap and streams each point's first hit as a
//               global cover index over a valid/ready interface. Every point
//               is emitted at most once between resets/clears; simultaneous
//               first hits drain lowest bit first.
// Ports       : clock         - rising-edge clock
//               reset         - asynchronous, active-high reset
//               valid         - per-point hit strobe (WIDTH bits)
//               clear         - synchronous wipe of all coverage state
//               out_valid     - a cover index is presented
//               out_ready     - harness accepts the presented index
//               out_index     - global cover index (COVER_INDEX + bit)
//               covered_count - number of points covered so far
//               all_covered   - every point of this instance covered
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_cover_collector
    import cover_pkg::*;
#(
    parameter int           WIDTH       = 7,
    parameter cover_index_t COVER_INDEX = 64'd0,
    parameter cover_index_t COVER_TOTAL = cover_index_t'(c_COVER_TOTAL_DEFAULT)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output cover_index_t                 out_index,
    output logic [$clog2(WIDTH+1)-1:0]   covered_count,
    output logic                         all_covered
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam int c_POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Elaboration-time parameter sanity checks.
    generate
        if (WIDTH < 1 || WIDTH > int'(c_MAX_WIDTH)) begin : g_bad_width
            $error("toggle_cover_collector: WIDTH must be within 1..64");
        end
        if (COVER_INDEX + cover_index_t'(WIDTH) > COVER_TOTAL) begin : g_bad_range
            $error("toggle_cover_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
        end
    endgenerate

    logic [WIDTH-1:0]   r_hit;
    logic [WIDTH-1:0]   r_pend;
    logic               r_out_valid;
    cover_index_t       r_out_index;
    logic [c_CNT_W-1:0] r_count;

    logic [WIDTH-1:0]   w_new;
    logic [WIDTH-1:0]   w_hit_next;
    logic [WIDTH-1:0]   w_pend_clr;
    logic [WIDTH-1:0]   w_pend_next;
    logic               w_load;
    logic               w_found;
    logic [c_POS_W-1:0] w_bitpos;
    cover_index_t       w_index;
    logic [63:0]        w_hit64;

    cover_prio_enc #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .req    (r_pend),
        .found  (w_found),
        .bitpos (w_bitpos)
    );

    always_comb begin
        // A point already in r_hit can never be re-queued, which is what
        // keeps the stream deduplicated even for hits landing on the point
        // currently being presented.
        w_new      = valid & ~r_hit;
        w_hit_next = r_hit | valid;

        // Output stage refills when empty or when its index is taken now.
        w_load     = !r_out_valid || out_ready;

        w_pend_clr = '0;
        if (w_load && w_found) begin
            w_pend_clr = WIDTH'(1) << w_bitpos;
        end
        w_pend_next = (r_pend & ~w_pend_clr) | w_new;

        w_index = COVER_INDEX + cover_index_t'(w_bitpos);

        w_hit64            = '0;
        w_hit64[WIDTH-1:0] = w_hit_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit       <= '0;
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_count     <= '0;
        end else if (clear) begin
            // Clear discards same-cycle hits and any unaccepted output.
            r_hit       <= '0;
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_count     <= '0;
        end else begin
            r_hit   <= w_hit_next;
            r_pend  <= w_pend_next;
            r_count <= c_CNT_W'(popcount(w_hit64));
            if (w_load) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_index <= w_index;
                end
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_index     = r_out_index;
    assign covered_count = r_count;
    assign all_covered   = (r_count == c_CNT_W'(WIDTH));

endmodule
`default_nettype wire

// File: tb/tb_toggle_cover_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_cover_collector
// Description : Self-checking bench for toggle_cover_collector. A set-based
//               model of covered / pending / presented points is compared
//               with the DUT every cycle; directed scenarios pin the model
//               with hand-computed index sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_cover_collector;

    localparam int          W  = 7;
    localparam logic [63:0] CI = 64'd100;

    logic         clock     = 1'b0;
    logic         reset     = 1'b0;
    logic         clear     = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] valid     = '0;
    logic         out_valid;
    logic         all_covered;
    logic [63:0]  out_index;
    logic [2:0]   covered_count;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clock = ~clock;

    toggle_cover_collector #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .COVER_TOTAL (64'd8744)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .clear         (clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .covered_count (covered_count),
        .all_covered   (all_covered)
    );

    // ------------------------------------------------------------------
    // Reference model: sets of covered and waiting points plus the one
    // index currently offered to the harness.
    // ------------------------------------------------------------------
    bit          m_covered[W];
    bit          m_waiting[W];
    bit          m_ov;
    logic [63:0] m_idx;
    int          m_cnt;

    logic [63:0] emitted[$];
    int          seq[8];

    task automatic model_wipe();
        for (int i = 0; i < W; i++) begin
            m_covered[i] = 1'b0;
            m_waiting[i] = 1'b0;
        end
        m_ov  = 1'b0;
        m_idx = '0;
        m_cnt = 0;
    endtask

    always @(posedge clock or posedge reset) begin
        int lowest;
        if (reset || clear) begin
            model_wipe();
        end else begin
            if (!m_ov || out_ready) begin
                lowest = -1;
                for (int i = 0; i < W; i++) begin
                    if (m_waiting[i]) begin
                        lowest = i;
                        break;
                    end
                end
                if (lowest >= 0) begin
                    m_ov = 1'b1;
                    m_idx = CI + 64'(lowest);
                    m_waiting[lowest] = 1'b0;
                end else begin
                    m_ov = 1'b0;
                end
            end
            for (int i = 0; i < W; i++) begin
                if (valid[i] && !m_covered[i]) begin
                    m_covered[i] = 1'b1;
                    m_waiting[i] = 1'b1;
                end
            end
            m_cnt = 0;
            for (int i = 0; i < W; i++) m_cnt += int'(m_covered[i]);
        end
    end

    // Record every accepted index as seen on the DUT interface.
    always @(posedge clock) begin
        if (!reset && !clear && out_valid === 1'b1 && out_ready)
            emitted.push_back(out_index);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the accepted-index log with the first n entries of seq
    // (offsets relative to CI).
    task automatic chk_seq(string name, int n);
        chk({name, "_len"}, 64'(emitted.size()), 64'(n));
        for (int i = 0; i < n && i < emitted.size(); i++)
            chk($sformatf("%s_%0d", name, i), emitted[i], CI + 64'(seq[i]));
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (started && !reset) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
            if (m_ov) chk("out_index", out_index, m_idx);
            chk("covered_count", 64'(covered_count), 64'(m_cnt));
            chk("all_covered", {63'd0, all_covered}, {63'd0, (m_cnt == W)});
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(logic [W-1:0] v);
        valid = v;
        cyc(1);
        valid = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        emitted.delete();
    endtask

    initial begin
        int n;
        logic [W-1:0] v;

        #1 reset = 1'b1;
        started = 1'b1;
        cyc(2);
        reset = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_index", out_index, 64'd0);
        chk("rst_count", 64'(covered_count), 64'd0);
        chk("rst_all", {63'd0, all_covered}, 64'd0);

        // Single hit on bit 2: index presented two edges after sampling.
        out_ready = 1'b1;
        pulse(7'b0000100);
        chk("single_count", 64'(covered_count), 64'd1);
        chk("single_early", {63'd0, out_valid}, 64'd0);
        cyc(1);
        chk("single_valid", {63'd0, out_valid}, 64'd1);
        chk("single_index", out_index, CI + 64'd2);
        cyc(6);
        seq = '{2, 0, 0, 0, 0, 0, 0, 0};
        chk_seq("single", 1);

        // Duplicate suppression.
        do_clear();
        for (int i = 0; i < 5; i++) begin
            pulse(7'b0000100);
            cyc(1);
        end
        cyc(4);
        chk_seq("dup", 1);

        // Burst of all points.
        do_clear();
        pulse(7'h7F);
        cyc(8);
        chk("burst_count", 64'(covered_count), 64'd7);
        chk("burst_all", {63'd0, all_covered}, 64'd1);
        seq = '{0, 1, 2, 3, 4, 5, 6, 0};
        chk_seq("burst", 7);

        // Backpressure with a new hit on bit 0 during the stall.
        do_clear();
        out_ready = 1'b0;
        pulse(7'b0001010);
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_index", out_index, CI + 64'd1);
            valid = (i == 3) ? 7'b0000001 : 7'b0000000;
            cyc(1);
        end
        valid = '0;
        out_ready = 1'b1;
        cyc(6);
        seq = '{1, 0, 3, 0, 0, 0, 0, 0};
        chk_seq("stall", 3);

        // Clear in the middle of a drain.
        do_clear();
        pulse(7'h7F);
        for (int i = 0; i < 20 && emitted.size() < 3; i++) cyc(1);
        chk("clr_wait", 64'(emitted.size()), 64'd3);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clr_valid", {63'd0, out_valid}, 64'd0);
        chk("clr_count", 64'(covered_count), 64'd0);
        pulse(7'b0000010);
        cyc(4);
        seq = '{0, 1, 2, 1, 0, 0, 0, 0};
        chk_seq("clr", 4);

        // Asynchronous reset between edges during a drain.
        do_clear();
        pulse(7'h7F);
        cyc(3);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_index", out_index, 64'd0);
        chk("arst_count", 64'(covered_count), 64'd0);
        chk("arst_all", {63'd0, all_covered}, 64'd0);
        cyc(2);
        reset = 1'b0;
        n = emitted.size();
        cyc(5);
        chk("arst_quiet", 64'(emitted.size()), 64'(n));
        pulse(7'b0100000);
        cyc(3);
        chk("arst_len", 64'(emitted.size()), 64'(n + 1));
        if (emitted.size() > 0)
            chk("arst_new", emitted[emitted.size() - 1], CI + 64'd5);

        // Randomised traffic with random backpressure and occasional clears.
        for (int c = 0; c < 3000; c++) begin
            v = '0;
            for (int b = 0; b < W; b++) v[b] = ($urandom_range(0, 9) == 0);
            valid     = v;
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 79) == 0);
            cyc(1);
        end
        valid = '0;
        clear = 1'b0;
        out_ready = 1'b1;
        cyc(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
